// File: rtl/lifo_arb_pkg.sv
// Op and lock-state encodings shared by the LIFO arbiter and its picker.
package lifo_arb_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/lifo_rr_pick.sv
// Combinational round-robin picker: first set bit of mask scanning upward from ptr, mod N.
module lifo_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;
  logic          found;

  // Explicit compare wrap so non-power-of-two N never lands on an unused index.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = wrap_add(ptr, k);
      if (!found && mask[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO stack between NUM_REQ requesters: round-robin grant, overflow/underflow
// screening, one-cycle registered responses and a per-requester lock with idle timeout.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 5,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_op,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      lifo_push,
  output logic                      lifo_pop,
  output logic [DATA_W-1:0]         lifo_data,
  input  logic [DATA_W-1:0]         lifo_q,
  input  logic                      lifo_empty,
  input  logic                      lifo_full,
  input  logic [CNT_W-1:0]          lifo_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  // state    | meaning
  // UNLOCKED | all valid requesters compete round-robin from rr_ptr
  // LOCKED   | only lock_owner may be granted; idle_cnt counts its idle cycles
  lock_state_e lock_state, lock_state_nx;

  logic [IW-1:0]      rr_ptr, rr_ptr_nx;
  logic [IW-1:0]      lock_owner, lock_owner_nx;
  logic [TW-1:0]      idle_cnt, idle_cnt_nx;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      pick_ptr;
  logic               grant_any;
  logic               grant_op;
  logic               grant_lock;
  logic [DATA_W-1:0]  grant_data;
  logic               stack_full;
  logic               stack_empty;
  logic               push_ok;
  logic               pop_ok;
  logic               op_err;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic               rsp_op_q;
  logic               rsp_err_q;
  logic               rsp_pop_q;

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
    if (p == IW'(NUM_REQ - 1)) return '0;
    return p + IW'(1);
  endfunction

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) owner_mask[i] = (lock_owner == IW'(i));
  end

  // A lock narrows the candidate set to the owner; the same picker then serves both modes.
  assign cand     = reset ? '0 :
                    (lock_state == LOCKED) ? (req_valid & owner_mask) : req_valid;
  assign pick_ptr = (lock_state == LOCKED) ? lock_owner : rr_ptr;

  lifo_rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .mask (cand),
    .ptr  (pick_ptr),
    .grant(grant),
    .index(grant_idx)
  );

  assign grant_any   = |grant;
  assign stack_full  = lifo_full  || (lifo_count >= CNT_W'(DEPTH));
  assign stack_empty = lifo_empty || (lifo_count == '0);

  always_comb begin
    grant_op   = |(grant & req_op);
    grant_lock = |(grant & req_lock);
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_data = req_data[i*DATA_W +: DATA_W];
    end
    push_ok = grant_any && (grant_op == OP_PUSH) && !stack_full;
    pop_ok  = grant_any && (grant_op == OP_POP)  && !stack_empty;
    op_err  = grant_any && !push_ok && !pop_ok;
  end

  assign req_ready = grant;
  assign lifo_push = push_ok;
  assign lifo_pop  = pop_ok;
  assign lifo_data = push_ok ? grant_data : '0;

  always_comb begin
    lock_state_nx = lock_state;
    lock_owner_nx = lock_owner;
    idle_cnt_nx   = idle_cnt;
    rr_ptr_nx     = rr_ptr;
    case (lock_state)
      UNLOCKED: begin
        if (grant_any) begin
          rr_ptr_nx = ptr_next(grant_idx);
          if (grant_lock) begin
            lock_state_nx = LOCKED;
            lock_owner_nx = grant_idx;
            idle_cnt_nx   = '0;
          end
        end
      end
      LOCKED: begin
        if (grant_any) begin
          if (grant_lock) begin
            idle_cnt_nx = '0;
          end else begin
            lock_state_nx = UNLOCKED;
            rr_ptr_nx     = ptr_next(lock_owner);
            idle_cnt_nx   = '0;
          end
        end else if (idle_cnt == TW'(LOCK_TIMEOUT - 1)) begin
          lock_state_nx = UNLOCKED;
          idle_cnt_nx   = '0;
        end else if (idle_cnt != TW'(LOCK_TIMEOUT)) begin
          idle_cnt_nx = idle_cnt + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_state  <= UNLOCKED;
      lock_owner  <= '0;
      idle_cnt    <= '0;
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_op_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_pop_q   <= 1'b0;
    end else begin
      lock_state  <= lock_state_nx;
      lock_owner  <= lock_owner_nx;
      idle_cnt    <= idle_cnt_nx;
      rr_ptr      <= rr_ptr_nx;
      rsp_valid_q <= grant;
      rsp_op_q    <= grant_any && grant_op;
      rsp_err_q   <= op_err;
      rsp_pop_q   <= pop_ok;
    end
  end

  // Popped data arrives on lifo_q the cycle after the pop, alongside the response strobe.
  assign rsp_valid = reset ? '0 : rsp_valid_q;
  assign rsp_op    = !reset && rsp_op_q;
  assign rsp_err   = !reset && rsp_err_q;
  assign rsp_data  = (!reset && rsp_pop_q) ? lifo_q : '0;

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
Shares one 16-bit hardware LIFO stack between NUM_REQ requesters, for example a call/return unit and a data-stack unit.
- Each cycle, grants at most one push or pop using round-robin arbitration.
- Screens overflow and underflow against the LIFO flags, so an illegal op never reaches the stack.
- Returns a registered response (ack, popped data or error) one cycle after grant.
- Supports a per-requester lock for atomic multi-op sequences, with a timeout release.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 16, stack word width; must match the LIFO
DEPTH, 16, LIFO depth; must match the attached LIFO
CNT_W, 5, width of lifo_count (log2(DEPTH)+1)
LOCK_TIMEOUT, 8, idle cycles after which a held lock auto-releases (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_op  in  NUM_REQ  per-requester op: 0 push, 1 pop
req_lock  in  NUM_REQ  keep grant after this op
req_data  in  NUM_REQ*DATA_W  push data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&&ready
rsp_valid  out  NUM_REQ  one-hot response strobe to requester
rsp_op  out  1  op being answered
rsp_err  out  1  1 = overflow (push) or underflow (pop); no LIFO access done
rsp_data  out  DATA_W  popped word; 0 for push and for error responses
lifo_push  out  1  to LIFO push
lifo_pop  out  1  to LIFO pop
lifo_data  out  DATA_W  to LIFO data
lifo_q  in  DATA_W  LIFO output; valid cycle after pop
lifo_empty  in  1  LIFO empty flag
lifo_full  in  1  LIFO full flag
lifo_count  in  CNT_W  LIFO occupancy

Behaviour:
- Reset (synchronous, clock, active-high): all outputs 0; rr_ptr=0; lock_valid=0; lock_owner=0; idle_cnt=0. The LIFO is reset by the same signal.
- Reset mid-operation: a response pending from the prior cycle is dropped; rsp_valid=0 in the cycle after reset is sampled.
- Arbitration (combinational, same cycle):
  - Candidates are all i with req_valid[i].
  - If lock_valid, only lock_owner is a candidate.
  - Otherwise grant the first candidate scanning from rr_ptr upward, mod NUM_REQ.
  - req_ready is one-hot or zero; it is never asserted during reset.
- Requester rule: req_op, req_data and req_lock stay stable while req_valid=1 and req_ready=0.
- Issue (same cycle as grant):
  - Push with lifo_full=0: lifo_push=1, lifo_data=req_data of grantee.
  - Pop with lifo_empty=0: lifo_pop=1.
  - Push with lifo_full=1, or pop with lifo_empty=1: no LIFO strobe; error response.
  - lifo_push and lifo_pop are never high together.
  - The LIFO flags are registered to post-op state, so back-to-back grants each see correct flags.
- Response (registered, latency 1):
  - Cycle after grant: rsp_valid[grantee]=1, rsp_op=op, rsp_err as determined at issue.
  - rsp_data = lifo_q for a successful pop, else 0.
  - Throughput is one op per cycle; there is no back-pressure on responses.
- rr_ptr: on any grant to i, rr_ptr <= (i+1) mod NUM_REQ; unchanged otherwise and while locked.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED: on a grant to i with req_lock[i]=1; lock_owner <= i, idle_cnt <= 0.
  - LOCKED, owner granted with req_lock=1: stay; idle_cnt <= 0.
  - LOCKED, owner granted with req_lock=0: -> UNLOCKED; rr_ptr <= owner+1. That op completes normally.
  - LOCKED, owner req_valid=0: idle_cnt++. When idle_cnt reaches LOCK_TIMEOUT-1 -> UNLOCKED (release on the LOCK_TIMEOUT-th idle cycle).
  - Error responses do not affect the lock.
- Width rules:
  - idle_cnt is clog2(LOCK_TIMEOUT+1) bits and saturates.
  - rr_ptr is clog2(NUM_REQ) bits, wrapping with an explicit compare (not power-of-2 wrap).

Decomposition:
- Package lifo_arb_pkg: OP_PUSH=1'b0, OP_POP=1'b1, lock state encoding (UNLOCKED/LOCKED).
- One sub-module, lifo_rr_pick: combinational round-robin picker. Inputs are the request mask and the pointer; outputs are one-hot grant and index. It is reused for lock masking.

Test Plan:
1. Req0 pushes 0x1111, 0x2222, then pops twice -> rsp_data 0x2222 then 0x1111, each one cycle after grant; rsp_err=0.
2. Both requesters hold push continuously after reset -> grants alternate 0,1,0,1; after 16 pushes lifo_full=1; 17th push gives rsp_err=1, lifo_push=0, lifo_count stays 16.
3. Pop on empty stack -> rsp_valid=1, rsp_err=1, rsp_data=0, lifo_pop never asserted.
4. Req1 pushes 0xAAAA with lock=1, then 0xBBBB with lock=0, while req0 requests continuously -> req0 not granted until the cycle after the 0xBBBB grant.
5. Req0 takes the lock then drops valid; req1 waits -> req1 granted in the first cycle after the lock auto-releases on the 8th idle cycle (LOCK_TIMEOUT=8).
6. Assert reset the cycle after a pop grant -> no rsp_valid that cycle; all outputs 0; first grant after reset goes to req0.
